servo_slew_limiter: RTL and testbench

- Sits between the 8-entry SPI-written duty register file and the per-channel ServoPWM instances.
- Takes raw 8-bit duty targets and emits rate-limited duty values. Each output moves toward its target by at most `step` counts per update tick, so servos slew smoothly instead of jumping.
- Uses one shared prescaler and a sequential channel scan; no per-channel arithmetic is duplicated.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 38 +++
 rtl/servo_slew_limiter.sv | 126 ++++++++++++
 tb/tb_servo_slew_limiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and slew arithmetic for the servo duty path.
package servo_pkg;

  localparam int NUM_CH_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef logic [DATA_W_DEFAULT-1:0] duty_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Move cur toward tgt by at most step; the one-bit-wider diff keeps the compare exact.
  function automatic duty_t slew_step(input duty_t cur, input duty_t tgt, input duty_t step);
    logic [DATA_W_DEFAULT:0] diff;
    duty_t                   nxt;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
    end
    if (diff <= {1'b0, step}) begin
      nxt = tgt;
    end else if (tgt > cur) begin
      nxt = cur + step;
    end else begin
      nxt = cur - step;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle pulse every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 2);

  if (TICK_DIV < 2) begin : g_div_check
    $error("tick_prescaler: TICK_DIV must be at least 2");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Counter wraps at TICK_DIV-1; the pulse is registered so it lines up with that count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_tick <= 1'b0;
    end else begin
      if (r_cnt == LAST_CNT) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_tick <= (r_cnt == PRE_LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/servo_slew_limiter.sv
// Rate-limits per-channel duty targets with one shared slew unit scanned
// across all channels once per prescaler tick.
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] target_flat,
  input  logic [DATA_W-1:0]        step,
  input  logic                     enable,
  output logic [NUM_CH*DATA_W-1:0] duty_flat,
  output logic [NUM_CH-1:0]        settled,
  output logic                     busy,
  output logic                     tick_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  if (TICK_DIV < NUM_CH + 2) begin : g_div_check
    $error("servo_slew_limiter: TICK_DIV must be >= NUM_CH+2 so scans never overlap");
  end
  if (DATA_W != DATA_W_DEFAULT) begin : g_width_check
    $error("servo_slew_limiter: DATA_W must match the shared duty_t width");
  end

  logic            w_tick;
  duty_t           w_tgt [NUM_CH];
  duty_t           r_cur [NUM_CH];
  duty_t           w_slew_nxt;
  logic [NUM_CH-1:0] r_settled;
  logic            r_busy;
  scan_state_t     r_state;
  scan_state_t     w_next_state;
  logic [CH_W-1:0] r_ch_idx;
  logic [CH_W-1:0] w_next_idx;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (w_tick)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign w_tgt[g]                     = target_flat[g*DATA_W +: DATA_W];
    assign duty_flat[g*DATA_W +: DATA_W] = r_cur[g];
  end

  assign w_slew_nxt = slew_step(r_cur[r_ch_idx], w_tgt[r_ch_idx], step);

  // Scan sequencing: a tick starts a sweep of every channel; bypass pins the FSM in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_ch_idx;
    if (!enable) begin
      w_next_state = IDLE;
      w_next_idx   = {CH_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            w_next_state = SCAN;
            w_next_idx   = {CH_W{1'b0}};
          end else begin
            w_next_state = IDLE;
          end
        end
        SCAN: begin
          if (r_ch_idx == LAST_CH) begin
            w_next_state = IDLE;
            w_next_idx   = {CH_W{1'b0}};
          end else begin
            w_next_idx = r_ch_idx + CH_W'(1);
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_idx   = {CH_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state register; busy mirrors the next state so it is high for exactly the scan cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ch_idx <= {CH_W{1'b0}};
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_ch_idx <= w_next_idx;
      r_busy   <= (w_next_state == SCAN);
    end
  end

  // Duty and settled registers: bypass loads every channel, scanning updates only the indexed one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        r_cur[i]     <= {DATA_W{1'b0}};
        r_settled[i] <= 1'b0;
      end else begin
        r_settled[i] <= (r_cur[i] == w_tgt[i]);
        if (!enable) begin
          r_cur[i] <= w_tgt[i];
        end else if ((r_state == SCAN) && (r_ch_idx == CH_W'(i))) begin
          r_cur[i] <= w_slew_nxt;
        end else begin
          r_cur[i] <= r_cur[i];
        end
      end
    end
  end

  assign settled  = r_settled;
  assign busy     = r_busy;
  assign tick_out = w_tick;

endmodule

// File: tb/tb_servo_slew_limiter.sv
// Directed bench for servo_slew_limiter with a 16-cycle update tick.
module tb_servo_slew_limiter;

  localparam int NUM_CH   = 8;
  localparam int DATA_W   = 8;
  localparam int TICK_DIV = 16;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH*DATA_W-1:0] target_flat;
  logic [DATA_W-1:0]        step;
  logic                     enable;
  logic [NUM_CH*DATA_W-1:0] duty_flat;
  logic [NUM_CH-1:0]        settled;
  logic                     busy;
  logic                     tick_out;

  int tests;
  int fails;

  servo_slew_limiter #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .target_flat(target_flat),
    .step       (step),
    .enable     (enable),
    .duty_flat  (duty_flat),
    .settled    (settled),
    .busy       (busy),
    .tick_out   (tick_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] duty_of(input int ch);
    return duty_flat[ch*DATA_W +: DATA_W];
  endfunction

  task automatic set_target(input int ch, input logic [DATA_W-1:0] v);
    target_flat[ch*DATA_W +: DATA_W] = v;
  endtask

  // Returns at the falling edge where tick_out is high; the scan then covers the next 9 edges.
  task automatic wait_tick();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick_out === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL wait_tick: tick_out stayed 0 for 40 cycles, required a pulse");
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    enable      = 1'b1;
    step        = 8'd3;
    target_flat = '0;
    repeat (3) @(negedge clk);
    tests++; if (duty_flat !== 64'h0) begin fails++; $display("FAIL reset_duty: got %h, required 0", duty_flat); end
    tests++; if (settled !== 8'h00) begin fails++; $display("FAIL reset_settled: got %h, required 00", settled); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (tick_out !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b, required 0", tick_out); end
    rst_n = 1'b1;
    set_target(0, 8'd10);
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_duty [4];
    exp_duty[0] = 8'd3; exp_duty[1] = 8'd6; exp_duty[2] = 8'd9; exp_duty[3] = 8'd10;
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ramp_busy_start: tick %0d got %b, required 1", k, busy); end
      @(negedge clk);
      tests++; if (duty_of(0) !== exp_duty[k]) begin fails++; $display("FAIL ramp_duty0: tick %0d got %0d, required %0d", k, duty_of(0), exp_duty[k]); end
      if (k == 0) begin
        repeat (6) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL scan_len_last: got busy %b, required 1", busy); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL scan_len_end: got busy %b, required 0", busy); end
      end else if (k == 3) begin
        tests++; if (settled[0] !== 1'b0) begin fails++; $display("FAIL settled_latency: got %b, required 0", settled[0]); end
        @(negedge clk);
        tests++; if (settled[0] !== 1'b1) begin fails++; $display("FAIL settled_set: got %b, required 1", settled[0]); end
      end else begin
        @(negedge clk);
      end
    end
    repeat (8) @(negedge clk);
    tests++; if (duty_flat[63:8] !== 56'h0) begin fails++; $display("FAIL ramp_others: got %h, required 0", duty_flat[63:8]); end
    tests++; if (settled !== 8'hFF) begin fails++; $display("FAIL ramp_settled_all: got %h, required ff", settled); end
  endtask

  task automatic test_ramp_down();
    logic [7:0] exp_duty [3];
    exp_duty[0] = 8'd195; exp_duty[1] = 8'd190; exp_duty[2] = 8'd190;
    enable = 1'b0;
    set_target(7, 8'd200);
    @(negedge clk);
    enable = 1'b1;
    set_target(7, 8'd190);
    step = 8'd5;
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      repeat (9) @(negedge clk);
      tests++; if (duty_of(7) !== exp_duty[k]) begin fails++; $display("FAIL ramp_down_duty7: tick %0d got %0d, required %0d", k, duty_of(7), exp_duty[k]); end
    end
  endtask

  task automatic test_hold_full_step();
    step = 8'd0;
    set_target(2, 8'd100);
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      repeat (9) @(negedge clk);
      tests++; if (duty_of(2) !== 8'd0) begin fails++; $display("FAIL hold_duty2: tick %0d got %0d, required 0", k, duty_of(2)); end
      tests++; if (settled[2] !== 1'b0) begin fails++; $display("FAIL hold_settled2: tick %0d got %b, required 0", k, settled[2]); end
    end
    step = 8'd255;
    wait_tick();
    repeat (9) @(negedge clk);
    tests++; if (duty_of(2) !== 8'd100) begin fails++; $display("FAIL full_step_duty2: got %0d, required 100", duty_of(2)); end
    tests++; if (settled[2] !== 1'b1) begin fails++; $display("FAIL full_step_settled2: got %b, required 1", settled[2]); end
  endtask

  task automatic test_bypass();
    int n_ticks;
    int first_pos;
    int second_pos;
    int busy_seen;
    enable = 1'b0;
    set_target(3, 8'd20);
    @(negedge clk);
    tests++; if (duty_of(3) !== 8'd20) begin fails++; $display("FAIL bypass_duty3_a: got %0d, required 20", duty_of(3)); end
    set_target(3, 8'd240);
    @(negedge clk);
    tests++; if (duty_of(3) !== 8'd240) begin fails++; $display("FAIL bypass_duty3_b: got %0d, required 240", duty_of(3)); end
    n_ticks = 0; first_pos = -1; second_pos = -1; busy_seen = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
      if (tick_out === 1'b1) begin
        if (n_ticks == 0) first_pos = i;
        if (n_ticks == 1) second_pos = i;
        n_ticks++;
      end
    end
    tests++; if (busy_seen != 0) begin fails++; $display("FAIL bypass_busy: busy high %0d cycles, required 0", busy_seen); end
    tests++; if (n_ticks != 3) begin fails++; $display("FAIL bypass_tick_count: got %0d, required 3", n_ticks); end
    tests++; if (second_pos - first_pos != TICK_DIV) begin fails++; $display("FAIL bypass_tick_period: got %0d, required %0d", second_pos - first_pos, TICK_DIV); end
    enable = 1'b1;
  endtask

  task automatic test_mid_scan_change();
    enable = 1'b0;
    set_target(1, 8'd100);
    set_target(5, 8'd100);
    @(negedge clk);
    enable = 1'b1;
    step   = 8'd10;
    wait_tick();
    repeat (3) @(negedge clk);
    set_target(1, 8'd150);
    set_target(5, 8'd150);
    repeat (6) @(negedge clk);
    tests++; if (duty_of(1) !== 8'd100) begin fails++; $display("FAIL mid_scan_ch1_now: got %0d, required 100", duty_of(1)); end
    tests++; if (duty_of(5) !== 8'd110) begin fails++; $display("FAIL mid_scan_ch5_now: got %0d, required 110", duty_of(5)); end
    wait_tick();
    repeat (9) @(negedge clk);
    tests++; if (duty_of(1) !== 8'd110) begin fails++; $display("FAIL mid_scan_ch1_next: got %0d, required 110", duty_of(1)); end
    tests++; if (duty_of(5) !== 8'd120) begin fails++; $display("FAIL mid_scan_ch5_next: got %0d, required 120", duty_of(5)); end
  endtask

  task automatic test_reset_mid_scan();
    int first_tick;
    wait_tick();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (duty_flat !== 64'h0) begin fails++; $display("FAIL rst_mid_duty: got %h, required 0", duty_flat); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    tests++; if (settled !== 8'h00) begin fails++; $display("FAIL rst_mid_settled: got %h, required 00", settled); end
    rst_n = 1'b1;
    // The reset edge is prescaler count 0, so the pulse lands TICK_DIV-1 edges after release.
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (tick_out === 1'b1) begin
        first_tick = i;
        break;
      end
    end
    tests++; if (first_tick != TICK_DIV - 1) begin fails++; $display("FAIL rst_mid_first_tick: got %0d, required %0d", first_tick, TICK_DIV - 1); end
    repeat (9) @(negedge clk);
    tests++; if (duty_flat !== {8'd10, 8'd0, 8'd10, 8'd0, 8'd10, 8'd10, 8'd10, 8'd10}) begin
      fails++; $display("FAIL rst_mid_first_scan: got %h, required 0a000a000a0a0a0a", duty_flat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_hold_full_step();
    test_bypass();
    test_mid_scan_change();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
